// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: default widths, the zero
// word and the clear-sequencer state encoding.
package regfile_mp_pkg;

    localparam int DefDataW = 32;
    localparam int DefAddrW = 5;

    localparam logic [DefDataW-1:0] ZeroWord = '0;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: blanking, zero register, same-cycle write
// forwarding (highest write port wins), else array data. Parity under REGFILE_PARITY_EN.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DefDataW,
    parameter int ADDR_W   = DefAddrW,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     blank,
    input  logic                     re,
    input  logic [ADDR_W-1:0]        raddr,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0]        arr_data,
`ifdef REGFILE_PARITY_EN
    input  logic                     arr_par,
    output logic                     perr,
`endif
    output logic [DATA_W-1:0]        rdata
);

    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Later iterations overwrite earlier ones, so the highest matching port wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rdata = '0;
`ifdef REGFILE_PARITY_EN
        perr  = 1'b0;
`endif
        if (!blank && re) begin
            if ((ZERO_REG != 0) && (raddr == '0)) begin
                rdata = '0;
            end else if (fwd_hit) begin
                rdata = fwd_data;
            end else begin
                rdata = arr_data;
`ifdef REGFILE_PARITY_EN
                perr  = (^arr_data) ^ arr_par;
`endif
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NUM_RD-read / NUM_WR-write register file with a clear sequencer
// instead of per-entry reset. Optional parity storage: define REGFILE_PARITY_EN.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W   = DefDataW,
    parameter int ADDR_W   = DefAddrW,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    output logic                     init_busy,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
`ifdef REGFILE_PARITY_EN
    output logic [NUM_RD-1:0]        perr,
`endif
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              blank;
    logic [DATA_W-1:0] regs [DEPTH];
`ifdef REGFILE_PARITY_EN
    logic              par_mem [DEPTH];
`endif

    assign blank = rst | (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= ST_READY;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state     <= ST_CLEAR;
                        clr_cnt   <= '0;
                        init_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array has no reset; the sweep owns it while clearing, write ports otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                regs[clr_cnt] <= DATA_W'(ZeroWord);
`ifdef REGFILE_PARITY_EN
                par_mem[clr_cnt] <= 1'b0;
`endif
            end else begin
                for (int i = 0; i < NUM_WR; i++) begin
                    if (we[i] && !((ZERO_REG != 0) && (waddr[i*ADDR_W +: ADDR_W] == '0))) begin
                        regs[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
`ifdef REGFILE_PARITY_EN
                        par_mem[waddr[i*ADDR_W +: ADDR_W]] <= ^wdata[i*DATA_W +: DATA_W];
`endif
                    end
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[j*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .NUM_WR  (NUM_WR),
            .ZERO_REG(ZERO_REG)
        ) u_rd (
            .blank   (blank),
            .re      (re[j]),
            .raddr   (ra),
            .we      (we),
            .waddr   (waddr),
            .wdata   (wdata),
            .arr_data(regs[ra]),
`ifdef REGFILE_PARITY_EN
            .arr_par (par_mem[ra]),
            .perr    (perr[j]),
`endif
            .rdata   (rdata[j*DATA_W +: DATA_W])
        );
    end

endmodule
